bounce_emulator: RTL
====================

BOUNCE_EMULATOR -- requirements
Module: bounce_emulator

Interface
REQ-001 Parameter DIV, default 1: clock cycles per bounce time unit; legal range >= 1.
REQ-002 Parameter BOUNCES, default 3: glitch pairs emitted before the final level; legal range 0..15.
REQ-003 Parameter SETTLE_CYCLES, default 64: cycles the final level is held before new requests are accepted; legal range >= 1.
REQ-004 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port press, input, 1 bit: clean intended button level, synchronous to clk.
REQ-007 Port x, output, 1 bit: emulated bouncy button contact, registered; drives push_button x input in loopback.
REQ-008 Port busy, output, 1 bit: high while a bounce/settle sequence is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-010 Block SHALL hold internal register settled, the last fully emitted level.
REQ-011 FSM states SHALL be IDLE, BOUNCE, SETTLE.
REQ-012 IDLE: on an edge where press != settled, SHALL latch target = press, drive x = target, set busy = 1, load pair counter with BOUNCES, and go to BOUNCE if BOUNCES > 0, else SETTLE.
REQ-013 IDLE with press == settled: x = settled, busy = 0, no state change.
REQ-014 Block SHALL keep an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every clk cycle in every state.
REQ-015 Every segment (each constant-x interval in BOUNCE) SHALL last (lfsr[2:0]+1)*DIV cycles, with lfsr sampled on the segment's first edge; range 1*DIV..8*DIV.
REQ-016 BOUNCE: at each segment end, x SHALL toggle; toggling to ~target starts a glitch, toggling back to target completes one pair and decrements the pair counter.
REQ-017 When the pair counter reaches 0 with x == target, FSM SHALL enter SETTLE; total x transitions per sequence SHALL be exactly 2*BOUNCES+1.
REQ-018 SETTLE: x SHALL hold target for exactly SETTLE_CYCLES cycles; on the final cycle, settled <= target, done = 1 for one cycle, busy = 0, next state IDLE.
REQ-019 Changes on press during BOUNCE or SETTLE SHALL be ignored (no restart, no abort).
REQ-020 After return to IDLE, if press != settled, a new sequence SHALL start on the next edge (done and new busy never overlap in the same cycle).
REQ-021 busy SHALL be high from the edge that leaves IDLE through the cycle before done; done and busy never high together.
REQ-022 Segment and settle counters SHALL be sized for 8*DIV and SETTLE_CYCLES without wrap; no counter may wrap during legal operation.
REQ-023 done SHALL never assert except at the end of SETTLE.

Reset
REQ-024 While rst = 1, asynchronously: state = IDLE, x = 0, settled = 0, busy = 0, done = 0, lfsr = 8'hA5, all counters = 0.
REQ-025 rst asserted mid-BOUNCE or mid-SETTLE SHALL abort the sequence immediately with no done pulse.
REQ-026 After rst deassertion with press = 1, a rising sequence SHALL start on the first clk edge.

Verification (DIV=1, BOUNCES=2, SETTLE_CYCLES=16 unless noted)
REQ-027 Reset: rst=1 for 20 ns with press=1 -> x=0, busy=0, done=0 throughout reset.
REQ-028 press 0->1 from idle -> x shows exactly 5 transitions ending at 1 (1,0,1,0,1), segment lengths match a bench LFSR model seeded 8'hA5, then x=1 for 16 cycles, done pulses once, busy falls the same edge.
REQ-029 press 1->0 during BOUNCE -> sequence completes to x=1 and done; next cycle a falling sequence (0,1,0,1,0) starts.
REQ-030 BOUNCES=0 -> press 0->1 yields one x transition, 16 settle cycles, one done pulse.
REQ-031 rst pulse mid-BOUNCE -> x=0, busy=0 within reset, no done; after release with press=0, block stays IDLE.
REQ-032 Loopback x into push_button with matching DIV, three press/release pairs -> exactly three single-cycle z pulses, none during glitches.

Source files
------------

// File: rtl/bounce_emulator.sv
// Emulates a bouncy mechanical contact: each change of the clean press level is
// replayed on x as a burst of pseudo-random glitches followed by a settle hold.
`timescale 1ns/1ps

module bounce_emulator #(
  parameter int unsigned DIV           = 1,
  parameter int unsigned BOUNCES       = 3,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic x,
  output logic busy,
  output logic done
);

  localparam int unsigned SEG_MAX  = 8 * DIV;
  localparam int unsigned SEGW     = $clog2(SEG_MAX + 1);
  localparam int unsigned SETW     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0]  SEED     = 8'hA5;
  localparam logic [SETW-1:0] SET_LOAD   = SETW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      PAIRS_LOAD = 4'(BOUNCES);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t          state;
  logic            settled;
  logic            target;
  logic [7:0]      lfsr;
  logic            lfsr_fb;
  logic [3:0]      pairs;
  logic [SEGW-1:0] seg_cnt;
  logic [SETW-1:0] set_cnt;
  logic [SEGW-1:0] seg_len_m1;

  // x^8+x^6+x^5+x^4+1, shifting towards the MSB
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  // Segment counters count down to zero, so load one less than the length
  assign seg_len_m1 = SEGW'((32'(lfsr[2:0]) + 32'd1) * DIV - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[6:0], lfsr_fb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x       <= 1'b0;
      settled <= 1'b0;
      target  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pairs   <= 4'd0;
      seg_cnt <= '0;
      set_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (press != settled) begin
            target <= press;
            x      <= press;
            busy   <= 1'b1;
            pairs  <= PAIRS_LOAD;
            if (BOUNCES != 0) begin
              seg_cnt <= seg_len_m1;
              state   <= BOUNCE;
            end else begin
              set_cnt <= SET_LOAD;
              state   <= SETTLE;
            end
          end else begin
            x <= settled;
          end
        end
        BOUNCE: begin
          if (seg_cnt != '0) begin
            seg_cnt <= seg_cnt - SEGW'(1);
          end else begin
            x <= ~x;
            if (x == target) begin
              seg_cnt <= seg_len_m1;
            end else begin
              // Returning to target closes one glitch pair
              pairs <= pairs - 4'd1;
              if (pairs == 4'd1) begin
                set_cnt <= SET_LOAD;
                state   <= SETTLE;
              end else begin
                seg_cnt <= seg_len_m1;
              end
            end
          end
        end
        SETTLE: begin
          if (set_cnt != '0) begin
            set_cnt <= set_cnt - SETW'(1);
          end else begin
            settled <= target;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
